// File: rtl/psum_pkg.sv
// Shared types and constants for the partial-sum ReLU/requantise/pack block.
package psum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int BYTES_PER_WORD = 4;
   localparam int ACC_W          = 19;
   localparam int U8_MAX         = 255;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on 'head' while not empty.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is forced to zero when empty so nothing stale leaks onto the bus.
   assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   // Pointer update; the extra MSB distinguishes full from empty.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents need no reset because empty masks the head.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/psum_relu_pack.sv
// Sums three PE partial sums plus bias, applies ReLU + shift requantise + uint8
// saturation, packs 4 bytes per word and streams words out over AXI4-Stream.
module psum_relu_pack
   import psum_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                start,
   input  logic signed [15:0]  bias,
   input  logic        [3:0]   shift,
   input  logic [CNT_W-1:0]    frame_words,
   input  logic signed [15:0]  ps0,
   input  logic signed [15:0]  ps1,
   input  logic signed [15:0]  ps2,
   input  logic                ps_valid,
   output logic [31:0]         m_axis_tdata,
   output logic                m_axis_tvalid,
   input  logic                m_axis_tready,
   output logic                m_axis_tlast,
   output logic                busy,
   output logic                done,
   output logic                overflow
);

   localparam int DATA_W = 16;
   localparam int LANE_W = $clog2(BYTES_PER_WORD);

   // ReLU, logical right shift of the non-negative sum, then clamp to uint8.
   function automatic logic [7:0] relu_requant(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b,
      input logic signed [DATA_W-1:0] c,
      input logic signed [DATA_W-1:0] d,
      input logic        [3:0]        sh
   );
      logic signed [ACC_W-1:0] s;
      logic        [ACC_W-1:0] v;
      s = $signed({{(ACC_W-DATA_W){a[DATA_W-1]}}, a})
        + $signed({{(ACC_W-DATA_W){b[DATA_W-1]}}, b})
        + $signed({{(ACC_W-DATA_W){c[DATA_W-1]}}, c})
        + $signed({{(ACC_W-DATA_W){d[DATA_W-1]}}, d});
      if (s[ACC_W-1]) return 8'd0;
      v = $unsigned(s) >> sh;
      if (v > ACC_W'(U8_MAX)) return 8'(U8_MAX);
      return v[7:0];
   endfunction

   state_t                    state;
   state_t                    state_nxt;
   logic                      done_nxt;
   logic signed [DATA_W-1:0]  bias_q;
   logic        [3:0]         shift_q;
   logic [CNT_W-1:0]          frame_words_q;
   logic [CNT_W-1:0]          word_cnt;
   logic [LANE_W-1:0]         lane;
   logic [23:0]               pack;
   logic [7:0]                pix;
   logic [31:0]               word;
   logic                      start_ok;
   logic                      accept;
   logic                      push;
   logic                      last;
   logic                      pop;
   logic                      full;
   logic                      empty;
   logic [32:0]               head;

   assign start_ok = (state == IDLE) && start && (frame_words != '0);
   assign accept   = (state == RUN) && ps_valid;
   assign pix      = relu_requant(ps0, ps1, ps2, bias_q, shift_q);
   // Lane 3 byte goes straight into the pushed word, so pack holds lanes 0..2 only.
   assign word     = {pix, pack};
   assign push     = accept && (lane == LANE_W'(BYTES_PER_WORD - 1));
   assign last     = (word_cnt == frame_words_q - CNT_W'(1));
   assign pop      = m_axis_tvalid && m_axis_tready;

   sync_fifo #(
      .WIDTH (33),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .push      (push),
      .push_data ({last, word}),
      .pop       (m_axis_tready),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign m_axis_tvalid = !empty;
   assign m_axis_tdata  = head[31:0];
   assign m_axis_tlast  = head[32];
   assign busy          = (state != IDLE);

   // Next-state and done-pulse decode.
   always_comb begin
      state_nxt = state;
      done_nxt  = 1'b0;
      case (state)
         IDLE:    if (start_ok) state_nxt = RUN;
         RUN:     if (push && last) state_nxt = DRAIN;
         DRAIN: begin
            if (empty) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register and registered done pulse.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= done_nxt;
      end
   end

   // Config latch, byte packing, word counting and sticky overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bias_q        <= '0;
         shift_q       <= '0;
         frame_words_q <= '0;
         word_cnt      <= '0;
         lane          <= '0;
         pack          <= '0;
         overflow      <= 1'b0;
      end else if (start_ok) begin
         bias_q        <= bias;
         shift_q       <= shift;
         frame_words_q <= frame_words;
         word_cnt      <= '0;
         lane          <= '0;
         overflow      <= 1'b0;
      end else if (accept) begin
         case (lane)
            2'd0:    pack[7:0]   <= pix;
            2'd1:    pack[15:8]  <= pix;
            2'd2:    pack[23:16] <= pix;
            default: ;
         endcase
         lane <= lane + LANE_W'(1);
         if (push) begin
            word_cnt <= word_cnt + CNT_W'(1);
            if (full && !pop) overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_psum_relu_pack.sv
// Scoreboard bench for psum_relu_pack: stimulus pushes expected words, a forked
// monitor pops and compares on every AXIS handshake.
module tb_psum_relu_pack;

   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 16;

   logic                clk = 1'b0;
   logic                rstn = 1'b0;
   logic                start = 1'b0;
   logic signed [15:0]  bias = '0;
   logic        [3:0]   shift = '0;
   logic [CNT_W-1:0]    frame_words = '0;
   logic signed [15:0]  ps0 = '0;
   logic signed [15:0]  ps1 = '0;
   logic signed [15:0]  ps2 = '0;
   logic                ps_valid = 1'b0;
   logic [31:0]         tdata;
   logic                tvalid;
   logic                tready = 1'b0;
   logic                tlast;
   logic                busy;
   logic                done;
   logic                overflow;

   int          compared = 0;
   int          mismatched = 0;
   int          n_out = 0;
   logic [32:0] exp_q [$];

   always #5 clk = ~clk;

   psum_relu_pack #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start         (start),
      .bias          (bias),
      .shift         (shift),
      .frame_words   (frame_words),
      .ps0           (ps0),
      .ps1           (ps1),
      .ps2           (ps2),
      .ps_valid      (ps_valid),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .busy          (busy),
      .done          (done),
      .overflow      (overflow)
   );

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (rstn && tvalid && tready) begin
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_word: got 0x%0h expected none", {tlast, tdata});
            end else begin
               chk("axis_word", {tlast, tdata}, exp_q.pop_front());
            end
            n_out++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int a, input int b, input int c);
      ps0 = 16'(a);
      ps1 = 16'(b);
      ps2 = 16'(c);
      ps_valid = 1'b1;
      tick();
      ps_valid = 1'b0;
   endtask

   task automatic start_frame(input int b, input int s, input int fw);
      bias = 16'(b);
      shift = 4'(s);
      frame_words = CNT_W'(fw);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic expw(input logic [31:0] w, input logic l);
      exp_q.push_back({l, w});
   endtask

   function automatic logic [31:0] seqw(input int b);
      return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
   endfunction

   task automatic wait_done(input string name, input bit toggle);
      bit got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(posedge clk);
         #1;
         if (toggle) tready = !tready;
         #3;
         if (done) got = 1'b1;
      end
      chk({name, "_done"}, 33'(got), 33'(1));
      if (got) begin
         chk({name, "_busy_at_done"}, 33'(busy), 33'(0));
         @(posedge clk);
         #4;
         chk({name, "_done_one_cycle"}, 33'(done), 33'(0));
      end
   endtask

   // Hard stop if something hangs despite the bounded waits.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n0;
      bit  seen;
      fork
         monitor();
      join_none

      // Power-on reset: every output low.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 33'(tvalid), 33'(0));
      chk("rst_tdata_tlast", {tlast, tdata}, 33'(0));
      chk("rst_busy_done_ovf", 33'({busy, done, overflow}), 33'(0));
      rstn = 1'b1;
      tick();

      // Basic single-word frame with latency check.
      tready = 1'b1;
      n0 = n_out;
      start_frame(0, 0, 1);
      chk("basic_busy", 33'(busy), 33'(1));
      beat(1, 0, 0);
      beat(2, 0, 0);
      beat(3, 0, 0);
      #2;
      chk("lat_before_4th", 33'(tvalid), 33'(0));
      expw(32'h04030201, 1'b1);
      beat(4, 0, 0);
      #2;
      chk("lat_after_4th", 33'(tvalid), 33'(1));
      wait_done("basic", 1'b0);
      chk("basic_words", 33'(n_out - n0), 33'(1));
      chk("basic_ovf", 33'(overflow), 33'(0));

      // Quantise: saturation, negative clamp, shifts, extreme bias.
      start_frame(0, 0, 1);
      expw(32'hFEFF00FF, 1'b1);
      beat(200, 200, 200);
      beat(-50, 10, 10);
      beat(255, 0, 0);
      beat(254, 0, 0);
      wait_done("q_shift0", 1'b0);

      start_frame(0, 2, 1);
      expw(32'h010019FF, 1'b1);
      beat(341, 341, 341);
      beat(100, 0, 0);
      beat(3, 0, 0);
      beat(4, 0, 0);
      wait_done("q_shift2", 1'b0);

      start_frame(-32768, 0, 1);
      expw(32'h0000FF00, 1'b1);
      beat(-32768, -32768, -32768);
      beat(32767, 32767, 32767);
      beat(32767, 0, 0);
      beat(32767, 1, 0);
      wait_done("q_negbias", 1'b0);

      start_frame(100, 1, 1);
      expw(32'hFF000032, 1'b1);
      beat(0, 0, 0);
      beat(-100, 0, 0);
      beat(-101, 0, 0);
      beat(410, 0, 0);
      wait_done("q_posbias", 1'b0);

      start_frame(32767, 15, 1);
      expw(32'h02000003, 1'b1);
      beat(32767, 32767, 32767);
      beat(0, 0, 0);
      beat(-32768, -32768, -32768);
      beat(32767, 32767, 1);
      wait_done("q_shift15", 1'b0);

      // Backpressure: tready toggles every cycle.
      n0 = n_out;
      start_frame(0, 0, 8);
      for (int i = 0; i < 32; i++) begin
         if (i % 4 == 0) expw(seqw(16 + i), (i / 4) == 7);
         tready = (i % 2 == 0);
         beat(16 + i, 0, 0);
      end
      wait_done("bp", 1'b1);
      chk("bp_words", 33'(n_out - n0), 33'(8));
      chk("bp_ovf", 33'(overflow), 33'(0));

      // Overflow: 20 words into a 16-deep FIFO with tready held low.
      tready = 1'b0;
      n0 = n_out;
      start_frame(0, 0, 20);
      for (int i = 0; i < 80; i++) begin
         if (i % 4 == 0 && i / 4 < 16) expw(seqw(i), 1'b0);
         beat(i, 0, 0);
      end
      chk("ovf_set", 33'(overflow), 33'(1));
      chk("ovf_tvalid", 33'(tvalid), 33'(1));
      chk("ovf_busy", 33'(busy), 33'(1));
      tready = 1'b1;
      wait_done("ovf", 1'b0);
      chk("ovf_words", 33'(n_out - n0), 33'(16));
      chk("ovf_sticky", 33'(overflow), 33'(1));

      // Full FIFO with simultaneous push and pop is not an overflow.
      tready = 1'b0;
      n0 = n_out;
      start_frame(0, 0, 20);
      chk("start_clears_ovf", 33'(overflow), 33'(0));
      for (int i = 0; i < 64; i++) begin
         if (i % 4 == 0) expw(seqw(i), 1'b0);
         beat(i, 0, 0);
      end
      chk("full_no_ovf", 33'(overflow), 33'(0));
      expw(seqw(64), 1'b0);
      for (int i = 64; i < 68; i++) begin
         if (i == 67) tready = 1'b1;
         beat(i, 0, 0);
      end
      tready = 1'b0;
      chk("pushpop_no_ovf", 33'(overflow), 33'(0));
      for (int i = 68; i < 72; i++) beat(i, 0, 0);
      chk("still_full_ovf", 33'(overflow), 33'(1));
      for (int i = 72; i < 80; i++) beat(i, 0, 0);
      tready = 1'b1;
      wait_done("pushpop", 1'b0);
      chk("pushpop_words", 33'(n_out - n0), 33'(17));

      // Reset mid-frame discards everything; beats without start do nothing.
      tready = 1'b0;
      start_frame(0, 0, 4);
      for (int i = 0; i < 6; i++) beat(i + 1, 0, 0);
      chk("pre_rst_tvalid", 33'(tvalid), 33'(1));
      rstn = 1'b0;
      #1;
      chk("midrst_tvalid", 33'(tvalid), 33'(0));
      chk("midrst_tdata_tlast", {tlast, tdata}, 33'(0));
      chk("midrst_busy_done_ovf", 33'({busy, done, overflow}), 33'(0));
      exp_q.delete();
      tick();
      tick();
      chk("midrst_no_done", 33'(done), 33'(0));
      rstn = 1'b1;
      tready = 1'b1;
      n0 = n_out;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         beat(10, 0, 0);
         if (tvalid || busy || done) seen = 1'b1;
      end
      chk("no_start_activity", 33'(seen), 33'(0));
      chk("no_start_words", 33'(n_out - n0), 33'(0));

      chk("queue_empty", 33'(exp_q.size()), 33'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
